// File: rtl/cam_pkg.sv
// Shared encodings and defaults for the CAM front-end controller.
// Op, status and FSM state types plus geometry defaults.
package cam_pkg;

  localparam int CAM_DEPTH = 16;
  localparam int CAM_KEY_W = 8;
  localparam int CAM_IDX_W = 5;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_MISS = 2'd1,
    ST_FULL = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    EVAL   = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/cam_free_pick.sv
// Lowest-clear-bit finder over the slot occupancy map.
// Reports the first free slot index and whether none is free.
module cam_free_pick
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int IDX_W = CAM_IDX_W
) (
  input  logic [DEPTH-1:0] occ,
  output logic [IDX_W-1:0] idx,
  output logic             all_full
);

  // Scan high to low so the lowest clear bit is the last one written.
  always_comb begin
    idx      = '0;
    all_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        idx      = IDX_W'(i);
        all_full = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// Request sequencer in front of the 16-entry CAM.
// Searches, allocates, deletes and answers one request at a time.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int KEY_W = CAM_KEY_W,
  parameter int IDX_W = CAM_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [KEY_W-1:0] req_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [1:0]       rsp_status,
  output logic [IDX_W-1:0] occ_count,
  output logic             cam_enable,
  output logic             cam_write,
  output logic [IDX_W-1:0] cam_addr,
  output logic [KEY_W-1:0] cam_data,
  output logic             cam_rst_n,
  input  logic [IDX_W-1:0] cam_out,
  input  logic             cam_found
);

  localparam int AW = $clog2(DEPTH);

  state_e           state;
  op_e              op;
  logic [KEY_W-1:0] key;
  logic [IDX_W-1:0] target;
  logic [DEPTH-1:0] occ;

  logic [IDX_W-1:0] free_idx;
  logic             all_full;
  logic             in_rng;
  logic             slot_occ;
  logic             live_hit;
  logic             stale_hit;
  logic             fresh;
  logic             ins_op;
  logic             del_op;
  logic             lk_op;

  function automatic logic [IDX_W-1:0] popcnt(
    input logic [DEPTH-1:0] v
  );
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + IDX_W'(v[i]);
    end
    return n;
  endfunction

  cam_free_pick #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_pick (
    .occ     (occ),
    .idx     (free_idx),
    .all_full(all_full)
  );

  assign cam_rst_n = ~rst;
  assign req_ready = (state == IDLE);

  // A CAM match only counts if the slot is still live.
  assign in_rng    = (cam_out < IDX_W'(DEPTH));
  assign slot_occ  = in_rng & occ[cam_out[AW-1:0]];
  assign live_hit  = cam_found & slot_occ;
  assign stale_hit = cam_found & in_rng & ~slot_occ;
  assign fresh     = ~live_hit & ~stale_hit;

  assign ins_op = (op == OP_INSERT);
  assign del_op = (op == OP_DELETE);
  assign lk_op  = ~ins_op & ~del_op;

  // Main sequencer: request capture, CAM cycles, occupancy, response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op         <= OP_LOOKUP;
      key        <= '0;
      target     <= '0;
      occ        <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_idx    <= '0;
      rsp_status <= ST_OK;
      cam_enable <= 1'b0;
      cam_write  <= 1'b0;
      cam_addr   <= '0;
      cam_data   <= '0;
    end else begin
      cam_enable <= 1'b0;
      cam_write  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op         <= op_e'(req_op);
            key        <= req_key;
            cam_enable <= 1'b1;
            cam_addr   <= '0;
            cam_data   <= req_key;
            state      <= SEARCH;
          end
        end
        SEARCH: begin
          state <= EVAL;
        end
        EVAL: begin
          state      <= RESP;
          rsp_valid  <= 1'b1;
          rsp_hit    <= 1'b0;
          rsp_idx    <= '0;
          rsp_status <= ST_MISS;
          unique case (1'b1)
            ins_op && live_hit: begin
              rsp_hit    <= 1'b1;
              rsp_idx    <= cam_out;
              rsp_status <= ST_OK;
            end
            ins_op && stale_hit: begin
              target     <= cam_out;
              rsp_valid  <= 1'b0;
              cam_enable <= 1'b1;
              cam_write  <= 1'b1;
              cam_addr   <= cam_out;
              cam_data   <= key;
              state      <= WRITE;
            end
            ins_op && fresh && !all_full: begin
              target     <= free_idx;
              rsp_valid  <= 1'b0;
              cam_enable <= 1'b1;
              cam_write  <= 1'b1;
              cam_addr   <= free_idx;
              cam_data   <= key;
              state      <= WRITE;
            end
            ins_op && fresh && all_full: begin
              rsp_status <= ST_FULL;
            end
            del_op && live_hit: begin
              occ[cam_out[AW-1:0]] <= 1'b0;
              rsp_hit    <= 1'b1;
              rsp_idx    <= cam_out;
              rsp_status <= ST_OK;
            end
            lk_op && live_hit: begin
              rsp_hit    <= 1'b1;
              rsp_idx    <= cam_out;
              rsp_status <= ST_OK;
            end
            default: begin
            end
          endcase
        end
        WRITE: begin
          occ[target[AW-1:0]] <= 1'b1;
          rsp_valid  <= 1'b1;
          rsp_hit    <= 1'b0;
          rsp_idx    <= target;
          rsp_status <= ST_OK;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Live-slot count trails the occupancy map by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_count <= '0;
    end else begin
      occ_count <= popcnt(occ);
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl with a behavioural 16x8 CAM behind it.
// Table of requests checked through an expectation queue.
module tb_cam_ctrl;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_key;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_hit;
  logic [4:0] rsp_idx;
  logic [1:0] rsp_status;
  logic [4:0] occ_count;
  logic       cam_enable;
  logic       cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic       cam_rst_n;
  logic [4:0] cam_out;
  logic       cam_found;

  cam_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx),
    .rsp_status(rsp_status),
    .occ_count (occ_count),
    .cam_enable(cam_enable),
    .cam_write (cam_write),
    .cam_addr  (cam_addr),
    .cam_data  (cam_data),
    .cam_rst_n (cam_rst_n),
    .cam_out   (cam_out),
    .cam_found (cam_found)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: registered first-match search, one-cycle write.
  logic [7:0]  cm [16];
  logic [15:0] cv;

  always @(posedge clk or negedge cam_rst_n) begin
    if (!cam_rst_n) begin
      cv        <= '0;
      cam_found <= 1'b0;
      cam_out   <= '0;
    end else if (cam_enable) begin
      if (cam_write) begin
        cm[cam_addr[3:0]] <= cam_data;
        cv[cam_addr[3:0]] <= 1'b1;
      end else begin
        logic       f;
        logic [4:0] o;
        f = 1'b0;
        o = '0;
        for (int i = 15; i >= 0; i--) begin
          if (cv[i] && cm[i] == cam_data) begin
            f = 1'b1;
            o = 5'(i);
          end
        end
        cam_found <= f;
        cam_out   <= o;
      end
    end
  end

  int wr_cnt = 0;
  always @(negedge clk) begin
    if (cam_write === 1'b1) wr_cnt++;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] key;
    logic       hit;
    logic [4:0] idx;
    logic [1:0] st;
    int         lat;
    int         wr;
    int         occ;
  } vec_t;

  vec_t vecs[$];
  vec_t exq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
    input logic [1:0] op, input logic [7:0] key,
    input logic hit, input logic [4:0] idx,
    input logic [1:0] st, input int lat,
    input int wr, input int occ
  );
    vec_t v;
    v.op  = op;  v.key = key; v.hit = hit;
    v.idx = idx; v.st  = st;  v.lat = lat;
    v.wr  = wr;  v.occ = occ;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v);
    vec_t e;
    int   lat;
    int   w0;
    logic done;
    exq.push_back(v);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_key   = v.key;
    rsp_ready = 1'b1;
    chk("req_ready", 32'(req_ready), 1);
    w0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = 1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1 lat++;
      end
    end
    e = exq.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: op=%0d key=%h no rsp_valid",
               e.op, e.key);
    end else begin
      chk($sformatf("hit k%h", e.key), 32'(rsp_hit), 32'(e.hit));
      chk($sformatf("idx k%h", e.key), 32'(rsp_idx), 32'(e.idx));
      chk($sformatf("st k%h", e.key), 32'(rsp_status), 32'(e.st));
      chk($sformatf("lat k%h", e.key), lat, e.lat);
      @(posedge clk);
      #1;
      chk($sformatf("wr k%h", e.key), wr_cnt - w0, e.wr);
      chk($sformatf("occ k%h", e.key), 32'(occ_count), e.occ);
      chk($sformatf("vdrop k%h", e.key), 32'(rsp_valid), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    logic done;

    // Request table.
    vecs.push_back(mk(OP_INSERT, 8'h10, 0, 0, ST_OK, 4, 1, 1));
    vecs.push_back(mk(OP_INSERT, 8'h11, 0, 1, ST_OK, 4, 1, 2));
    vecs.push_back(mk(OP_INSERT, 8'h10, 1, 0, ST_OK, 3, 0, 2));
    vecs.push_back(mk(OP_LOOKUP, 8'h55, 0, 0, ST_MISS, 3, 0, 2));
    vecs.push_back(mk(OP_LOOKUP, 8'h11, 1, 1, ST_OK, 3, 0, 2));
    vecs.push_back(mk(OP_RSVD, 8'h10, 1, 0, ST_OK, 3, 0, 2));
    vecs.push_back(mk(OP_DELETE, 8'h77, 0, 0, ST_MISS, 3, 0, 2));
    for (int i = 0; i < 14; i++) begin
      vecs.push_back(mk(OP_INSERT, 8'(8'h20 + i), 0,
                        5'(i + 2), ST_OK, 4, 1, i + 3));
    end
    vecs.push_back(mk(OP_INSERT, 8'h55, 0, 0, ST_FULL, 3, 0, 16));
    vecs.push_back(mk(OP_DELETE, 8'h23, 1, 5, ST_OK, 3, 0, 15));
    vecs.push_back(mk(OP_LOOKUP, 8'h23, 0, 0, ST_MISS, 3, 0, 15));
    vecs.push_back(mk(OP_INSERT, 8'hAA, 0, 5, ST_OK, 4, 1, 16));
    vecs.push_back(mk(OP_DELETE, 8'hAA, 1, 5, ST_OK, 3, 0, 15));
    vecs.push_back(mk(OP_DELETE, 8'h24, 1, 6, ST_OK, 3, 0, 14));
    vecs.push_back(mk(OP_INSERT, 8'h24, 0, 6, ST_OK, 4, 1, 15));
    vecs.push_back(mk(OP_INSERT, 8'h99, 0, 5, ST_OK, 4, 1, 16));

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_key   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst occ_count", 32'(occ_count), 0);
    chk("rst cam_enable", 32'(cam_enable), 0);
    chk("rst cam_rst_n", 32'(cam_rst_n), 0);
    chk("rst rsp_idx", 32'(rsp_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("cam_rst_n rel", 32'(cam_rst_n), 1);

    foreach (vecs[i]) do_req(vecs[i]);

    // Back-pressure: response must hold while rsp_ready is low.
    exq.push_back(mk(OP_LOOKUP, 8'h11, 1, 1, ST_OK, 3, 0, 16));
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_LOOKUP;
    req_key   = 8'h11;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rsp_valid === 1'b1) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    e = exq.pop_front();
    chk("hold seen", 32'(done), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold valid", 32'(rsp_valid), 1);
      chk("hold hit", 32'(rsp_hit), 32'(e.hit));
      chk("hold idx", 32'(rsp_idx), 32'(e.idx));
      chk("hold st", 32'(rsp_status), 32'(e.st));
      chk("hold rdy", 32'(req_ready), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("hold drop", 32'(rsp_valid), 0);
    chk("hold idle", 32'(req_ready), 1);

    // Free slot 0, then reset in the middle of the refill write.
    do_req(mk(OP_DELETE, 8'h10, 1, 0, ST_OK, 3, 0, 15));
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_key   = 8'h33;
    @(posedge clk);
    #1 req_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cam_write === 1'b1) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("write seen", 32'(done), 1);
    chk("write addr", 32'(cam_addr), 0);
    rst = 1'b1;
    #1;
    chk("mid rst cam_rst_n", 32'(cam_rst_n), 0);
    chk("mid rst rsp_valid", 32'(rsp_valid), 0);
    chk("mid rst cam_write", 32'(cam_write), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid rst occ", 32'(occ_count), 0);
    chk("mid rst rsp_v2", 32'(rsp_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    do_req(mk(OP_LOOKUP, 8'h11, 0, 0, ST_MISS, 3, 0, 0));
    do_req(mk(OP_INSERT, 8'h11, 0, 0, ST_OK, 4, 1, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Front-end controller directly upstream of the 16-entry, 8-bit-key `cam`; the only agent driving the CAM's enable/write/addr/data ports.
- Accepts LOOKUP / INSERT / DELETE requests over a valid/ready handshake.
- Sequences the CAM search and write cycles, tracks slot occupancy, and returns one response per request over a valid/ready handshake.
- Converts the CAM's raw first-match result into a clean hit/index/status response.

Parameters:
- DEPTH, 16: number of CAM slots managed (`addr` values 0..DEPTH-1).
- KEY_W, 8: key width; equals the CAM data width.
- IDX_W, 5: CAM address/result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_op  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved (treated as LOOKUP).
- req_key  in  KEY_W  key to search, insert or delete.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_hit  out  1  key was present (before the op).
- rsp_idx  out  IDX_W  slot index of hit or newly allocated slot; 0 when none.
- rsp_status  out  2  0=OK, 1=MISS, 2=FULL.
- occ_count  out  IDX_W  number of live slots, 0..DEPTH.
- cam_enable  out  1  to CAM `enable`.
- cam_write  out  1  to CAM `write`.
- cam_addr  out  IDX_W  to CAM `addr`.
- cam_data  out  KEY_W  to CAM `data`.
- cam_rst_n  out  1  to CAM `rst_n`; equals ~rst, combinational.
- cam_out  in  IDX_W  from CAM `out`.
- cam_found  in  1  from CAM `found`.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE; occupancy bitmap=0; occ_count=0.
  - rsp_valid=0, rsp_hit=0, rsp_idx=0, rsp_status=0.
  - cam_enable=0, cam_write=0, cam_addr=0, cam_data=0.
  - cam_rst_n=0, so the CAM is cleared with it.
  - Reset mid-operation abandons any request in flight; no response is produced.
- CAM timing contract: search/write is presented for one cycle and captured at the next rising edge. cam_found/cam_out are valid in the cycle after the search cycle.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op and key, go to SEARCH.
- SEARCH (1 cycle):
  - cam_enable=1, cam_write=0, cam_data=key.
  - Next state is EVAL.
- EVAL (1 cycle): sample cam_found/cam_out.
  - live_hit = cam_found & occ[cam_out].
  - A stale hit (found but slot unoccupied) is treated as a miss. On INSERT, that stale slot is the write target (reuse).
  - LOOKUP: hit → RESP, OK, idx=cam_out. Miss → RESP, MISS, idx=0.
  - DELETE: hit → clear occ[cam_out], RESP, OK, hit=1, idx=cam_out. Miss → RESP, MISS.
  - INSERT, live hit: RESP, OK, hit=1, idx=cam_out; no write.
  - INSERT, stale hit: target=cam_out, go to WRITE.
  - INSERT, otherwise: target=lowest clear occupancy bit, go to WRITE. If all DEPTH bits are set → RESP, FULL, idx=0.
- WRITE (1 cycle):
  - cam_enable=1, cam_write=1, cam_addr=target, cam_data=key.
  - Set occ[target]; go to RESP with OK, hit=0, idx=target.
- RESP:
  - rsp_valid=1; fields stay stable until rsp_ready.
  - On rsp_valid & rsp_ready → IDLE; rsp_valid drops next cycle.
- Latency from accept edge to rsp_valid:
  - LOOKUP / DELETE / INSERT-hit / INSERT-full: 3 cycles.
  - INSERT-write: 4 cycles.
- Throughput: one request in flight; req_ready=0 outside IDLE.
- occ_count: popcount of occupancy, updated the cycle after a set or clear.
- Invariant: no two live slots hold the same key. Every insert searches first; the CAM's first-match priority therefore never masks a live entry.

Decomposition:
- Package cam_pkg:
  - op encodings (OP_LOOKUP/OP_INSERT/OP_DELETE);
  - status encodings (ST_OK/ST_MISS/ST_FULL);
  - state encoding (IDLE, SEARCH, EVAL, WRITE, RESP);
  - DEPTH, KEY_W, IDX_W defaults.
- Sub-module cam_free_pick: combinational lowest-clear-bit priority encoder over the DEPTH-bit occupancy. Outputs IDX_W index plus an all_full flag.

Test Plan:
- Reset, INSERT 0x10 → rsp after 4 cycles: OK, hit=0, idx=0, occ_count=1. INSERT 0x11 → idx=1.
- INSERT 0x10 again → OK, hit=1, idx=0, no cam_write pulse, occ_count unchanged.
- LOOKUP 0x55 on a non-full table → MISS, hit=0, idx=0, latency 3.
- INSERT 0x20..0x2F until full; INSERT 0x55 → FULL, idx=0, occ_count=16.
- DELETE key at idx 5 → OK, idx=5, occ_count=15. LOOKUP same key → MISS (stale masked). INSERT 0xAA → idx=5 (stale slot or lowest free).
- Hold rsp_ready=0 for 5 cycles: fields stable, req_ready=0. Assert rst during WRITE: no rsp_valid, cam_rst_n low, occ_count=0, next LOOKUP → MISS.
